// File: rtl/cache_refill_arbiter_pkg.sv
// Shared types and sizing for the I/D cache refill arbiter.
// One burst is one cache line of BURST_BEATS beats.
package cache_refill_arbiter_pkg;

  localparam int ADDR_WIDTH  = 32;
  localparam int DATA_WIDTH  = 32;
  localparam int BURST_BEATS = 8;
  localparam int BEAT_CNT_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_WBEATS = 3'd2,
    ST_RBEATS = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  // One-hot {D,I} ownership of the memory port.
  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_I    = 2'b01,
    GNT_D    = 2'b10
  } grant_t;

  function automatic logic is_last_beat(input logic [BEAT_CNT_W-1:0] cnt);
    return cnt == BEAT_CNT_W'(BURST_BEATS - 1);
  endfunction

endpackage

// File: rtl/cache_refill_arbiter_if.sv
// Cache-side and memory-side signals of the refill arbiter.
// master = arbiter view, slave = caches plus memory view.
interface cache_refill_arbiter_if;
  import cache_refill_arbiter_pkg::*;

  logic                  icache_req;
  logic [ADDR_WIDTH-1:0] icache_addr;
  logic [DATA_WIDTH-1:0] icache_rdata;
  logic                  icache_rvalid;
  logic                  icache_done;

  logic                  dcache_req;
  logic                  dcache_write;
  logic [ADDR_WIDTH-1:0] dcache_addr;
  logic [DATA_WIDTH-1:0] dcache_wdata;
  logic                  dcache_wready;
  logic [DATA_WIDTH-1:0] dcache_rdata;
  logic                  dcache_rvalid;
  logic                  dcache_done;

  logic                  mem_cmd_valid;
  logic                  mem_cmd_ready;
  logic                  mem_cmd_write;
  logic [ADDR_WIDTH-1:0] mem_cmd_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_wvalid;
  logic                  mem_wready;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rvalid;

  logic [1:0]            grant;

  modport master (
    input  icache_req, icache_addr, dcache_req, dcache_write, dcache_addr, dcache_wdata,
           mem_cmd_ready, mem_wready, mem_rdata, mem_rvalid,
    output icache_rdata, icache_rvalid, icache_done, dcache_wready, dcache_rdata,
           dcache_rvalid, dcache_done, mem_cmd_valid, mem_cmd_write, mem_cmd_addr,
           mem_wdata, mem_wvalid, grant
  );

  modport slave (
    output icache_req, icache_addr, dcache_req, dcache_write, dcache_addr, dcache_wdata,
           mem_cmd_ready, mem_wready, mem_rdata, mem_rvalid,
    input  icache_rdata, icache_rvalid, icache_done, dcache_wready, dcache_rdata,
           dcache_rvalid, dcache_done, mem_cmd_valid, mem_cmd_write, mem_cmd_addr,
           mem_wdata, mem_wvalid, grant
  );

endinterface

// File: rtl/cache_refill_arbiter_rr.sv
// Two-way round-robin arbiter: req = {D,I}; pointer moves on every granted update.
module refill_rr_arbiter
  import cache_refill_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output grant_t     grant
);

  logic prefer_d_r;

  always_comb begin
    grant = GNT_NONE;
    case (req)
      2'b01:   grant = GNT_I;
      2'b10:   grant = GNT_D;
      2'b11:   grant = prefer_d_r ? GNT_D : GNT_I;
      default: grant = GNT_NONE;
    endcase
  end

  // After a grant the other side is favoured next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prefer_d_r <= 1'b1;
    end else if (update && (grant != GNT_NONE)) begin
      prefer_d_r <= (grant == GNT_I);
    end else begin
      prefer_d_r <= prefer_d_r;
    end
  end

endmodule

// File: rtl/cache_refill_arbiter.sv
// Shares one burst memory port between I-cache refills and D-cache refills/writebacks.
// Sequence per transaction: IDLE (grant) -> CMD -> RBEATS/WBEATS -> RESP (done pulse).
module cache_refill_arbiter
  import cache_refill_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  cache_refill_arbiter_if.master bus
);

  logic [1:0]            rst_sync_r;
  logic                  rst_int;
  state_t                state_r, state_s;
  grant_t                arb_grant_s, owner_r;
  logic                  arb_update_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  write_r;
  logic [BEAT_CNT_W-1:0] cnt_r, cnt_s;
  logic [DATA_WIDTH-1:0] irdata_r, drdata_r;
  logic                  irvalid_r, drvalid_r, idone_r, ddone_r;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_sync_r <= 2'b11;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b0};
    end
  end
  assign rst_int = rst_sync_r[1];

  refill_rr_arbiter u_arb (
    .clk    (clk),
    .rst    (rst_int),
    .req    ({bus.dcache_req, bus.icache_req}),
    .update (arb_update_s),
    .grant  (arb_grant_s)
  );

  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    arb_update_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (arb_grant_s != GNT_NONE) begin
          state_s      = ST_CMD;
          arb_update_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (bus.mem_cmd_ready) begin
          state_s = write_r ? ST_WBEATS : ST_RBEATS;
          cnt_s   = {BEAT_CNT_W{1'b0}};
        end else begin
          state_s = ST_CMD;
        end
      end
      ST_RBEATS, ST_WBEATS: begin
        if ((state_r == ST_RBEATS) ? bus.mem_rvalid : bus.mem_wready) begin
          cnt_s   = cnt_r + BEAT_CNT_W'(1);
          state_s = is_last_beat(cnt_r) ? ST_RESP : state_r;
        end else begin
          state_s = state_r;
        end
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, beat counter and the request latched at grant time.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state_r <= ST_IDLE;
      cnt_r   <= {BEAT_CNT_W{1'b0}};
      owner_r <= GNT_NONE;
      addr_r  <= {ADDR_WIDTH{1'b0}};
      write_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (arb_update_s) begin
        owner_r <= arb_grant_s;
        addr_r  <= (arb_grant_s == GNT_D) ? bus.dcache_addr : bus.icache_addr;
        write_r <= (arb_grant_s == GNT_D) && bus.dcache_write;
      end else if (state_r == ST_RESP) begin
        owner_r <= GNT_NONE;
      end else begin
        owner_r <= owner_r;
      end
    end
  end

  // Read beats are steered to the owner one cycle late; DONE lands with the last of them.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      irdata_r  <= {DATA_WIDTH{1'b0}};
      drdata_r  <= {DATA_WIDTH{1'b0}};
      irvalid_r <= 1'b0;
      drvalid_r <= 1'b0;
      idone_r   <= 1'b0;
      ddone_r   <= 1'b0;
    end else begin
      irvalid_r <= (state_r == ST_RBEATS) && bus.mem_rvalid && (owner_r == GNT_I);
      drvalid_r <= (state_r == ST_RBEATS) && bus.mem_rvalid && (owner_r == GNT_D);
      irdata_r  <= ((state_r == ST_RBEATS) && bus.mem_rvalid && (owner_r == GNT_I)) ? bus.mem_rdata : irdata_r;
      drdata_r  <= ((state_r == ST_RBEATS) && bus.mem_rvalid && (owner_r == GNT_D)) ? bus.mem_rdata : drdata_r;
      idone_r   <= (state_s == ST_RESP) && (state_r != ST_RESP) && (owner_r == GNT_I);
      ddone_r   <= (state_s == ST_RESP) && (state_r != ST_RESP) && (owner_r == GNT_D);
    end
  end

  assign bus.icache_rdata  = irdata_r;
  assign bus.icache_rvalid = irvalid_r;
  assign bus.icache_done   = idone_r;
  assign bus.dcache_rdata  = drdata_r;
  assign bus.dcache_rvalid = drvalid_r;
  assign bus.dcache_done   = ddone_r;
  assign bus.grant         = owner_r;

  assign bus.mem_cmd_valid = (state_r == ST_CMD);
  assign bus.mem_cmd_addr  = (state_r == ST_CMD) ? addr_r : {ADDR_WIDTH{1'b0}};
  assign bus.mem_cmd_write = (state_r == ST_CMD) && write_r;
  assign bus.mem_wvalid    = (state_r == ST_WBEATS);
  assign bus.mem_wdata     = (state_r == ST_WBEATS) ? bus.dcache_wdata : {DATA_WIDTH{1'b0}};
  assign bus.dcache_wready = (state_r == ST_WBEATS) && bus.mem_wready;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed bench for cache_refill_arbiter: a table of arbitration/transaction vectors
// plus hand-written sequences for reset mid-burst and stray memory beats.
module tb_cache_refill_arbiter;
  import cache_refill_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cache_refill_arbiter_if bus_if ();

  cache_refill_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic        ireq;
    logic        dreq;
    logic        dwrite;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] base;
    grant_t      exp_g;
    logic [31:0] exp_addr;
    logic        exp_write;
    int          cmd_wait;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {bus_if.grant, bus_if.icache_rvalid, bus_if.icache_done,
                          bus_if.dcache_rvalid, bus_if.dcache_done, bus_if.dcache_wready,
                          bus_if.mem_cmd_valid, bus_if.mem_cmd_write, bus_if.mem_wvalid}, 64'd0);
    check({tag, "_data"}, |{bus_if.icache_rdata, bus_if.dcache_rdata,
                            bus_if.mem_cmd_addr, bus_if.mem_wdata}, 64'd0);
  endtask

  // Runs one transaction from IDLE (requests already driven) through to the next IDLE.
  task automatic do_txn(input grant_t exp_g, input logic [31:0] exp_addr, input logic exp_write,
                        input logic [31:0] base, input int cmd_wait, input int exp_lat);
    int lat = 0;
    int beat = 0;
    int cyc = 0;
    logic wr = 1'b1;
    logic o_rv, o_dn, x_rv;
    logic [31:0] o_rd;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus_if.mem_cmd_valid && lat < 8);
    check("cmd_valid", bus_if.mem_cmd_valid, 64'd1);
    if (exp_lat != 0) check("cmd_latency", lat, exp_lat);
    check("grant", bus_if.grant, exp_g);
    check("cmd_addr", bus_if.mem_cmd_addr, exp_addr);
    check("cmd_write", bus_if.mem_cmd_write, exp_write);
    for (int w = 0; w < cmd_wait; w++) begin
      bus_if.mem_rvalid = (w == 1);
      bus_if.mem_rdata  = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      bus_if.mem_rvalid = 1'b0;
      check("cmd_hold", {bus_if.mem_cmd_valid, bus_if.mem_cmd_addr, bus_if.mem_cmd_write},
            {1'b1, exp_addr, exp_write});
      check("cmd_quiet", {bus_if.icache_rvalid, bus_if.dcache_rvalid, bus_if.mem_wvalid}, 64'd0);
    end
    bus_if.mem_cmd_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.mem_cmd_ready = 1'b0;
    if (!exp_write) begin
      for (int k = 0; k < 8; k++) begin
        bus_if.mem_rvalid = 1'b1;
        bus_if.mem_rdata  = base + 32'(k);
        @(posedge clk); #1;
        bus_if.mem_rvalid = 1'b0;
        o_rv = (exp_g == GNT_I) ? bus_if.icache_rvalid : bus_if.dcache_rvalid;
        o_rd = (exp_g == GNT_I) ? bus_if.icache_rdata  : bus_if.dcache_rdata;
        o_dn = (exp_g == GNT_I) ? bus_if.icache_done   : bus_if.dcache_done;
        x_rv = (exp_g == GNT_I) ? bus_if.dcache_rvalid : bus_if.icache_rvalid;
        check("rvalid", o_rv, 64'd1);
        check("rdata", o_rd, base + 32'(k));
        check("other_rvalid", x_rv, 64'd0);
        check("done_with_beat", o_dn, (k == 7) ? 64'd1 : 64'd0);
      end
    end else begin
      bus_if.dcache_wdata = base;
      while (beat < 8 && cyc < 40) begin
        bus_if.mem_wready = wr;
        #1;
        check("wvalid", bus_if.mem_wvalid, 64'd1);
        check("wdata", bus_if.mem_wdata, base + 32'(beat));
        check("wready", bus_if.dcache_wready, wr);
        check("wdone_early", bus_if.dcache_done, 64'd0);
        @(posedge clk); #1;
        if (wr) beat++;
        bus_if.dcache_wdata = base + 32'(beat);
        wr = ~wr;
        cyc++;
      end
      bus_if.mem_wready = 1'b0;
      check("wbeats", beat, 64'd8);
      check("wdone", bus_if.dcache_done, 64'd1);
      bus_if.mem_wready = 1'b1;
      #1;
      check("wready_outside", {bus_if.dcache_wready, bus_if.mem_wvalid}, 64'd0);
      bus_if.mem_wready = 1'b0;
    end
    if (exp_g == GNT_I) bus_if.icache_req = 1'b0;
    else bus_if.dcache_req = 1'b0;
    @(posedge clk); #1;
    check("idle_after", {bus_if.grant, bus_if.icache_done, bus_if.dcache_done}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0,   32'hA0, GNT_I, 32'h100, 1'b0, 0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h140, 32'h180, 32'hB0, GNT_D, 32'h180, 1'b0, 0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h140, 32'h1C0, 32'hC0, GNT_I, 32'h140, 1'b0, 0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h1C0, 32'hD0, GNT_D, 32'h1C0, 1'b0, 5};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h240, 32'h200, 32'hE0, GNT_I, 32'h240, 1'b0, 0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h200, 32'h30, GNT_D, 32'h200, 1'b1, 5};

    bus_if.icache_req    = 1'b0;
    bus_if.icache_addr   = 32'h0;
    bus_if.dcache_req    = 1'b0;
    bus_if.dcache_write  = 1'b0;
    bus_if.dcache_addr   = 32'h0;
    bus_if.dcache_wdata  = 32'h0;
    bus_if.mem_cmd_ready = 1'b0;
    bus_if.mem_wready    = 1'b0;
    bus_if.mem_rdata     = 32'h0;
    bus_if.mem_rvalid    = 1'b0;

    #12;
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("idle");

    // Stray read beat while idle must not reach either cache.
    bus_if.mem_rvalid = 1'b1;
    bus_if.mem_rdata  = 32'h5555_AAAA;
    @(posedge clk); #1;
    bus_if.mem_rvalid = 1'b0;
    check("idle_rvalid", {bus_if.icache_rvalid, bus_if.dcache_rvalid}, 64'd0);

    for (int v = 0; v < 6; v++) begin
      bus_if.icache_req   = vecs[v].ireq;
      bus_if.icache_addr  = vecs[v].iaddr;
      bus_if.dcache_req   = vecs[v].dreq;
      bus_if.dcache_addr  = vecs[v].daddr;
      bus_if.dcache_write = vecs[v].dwrite;
      do_txn(vecs[v].exp_g, vecs[v].exp_addr, vecs[v].exp_write, vecs[v].base,
             vecs[v].cmd_wait, 1);
    end
    bus_if.dcache_write = 1'b0;

    // Reset during read beat 3; the held request must restart with the same address.
    bus_if.icache_req  = 1'b1;
    bus_if.icache_addr = 32'h300;
    @(posedge clk); #1;
    check("rst_seq_cmd", bus_if.mem_cmd_valid, 64'd1);
    bus_if.mem_cmd_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.mem_cmd_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus_if.mem_rvalid = 1'b1;
      bus_if.mem_rdata  = 32'h70 + 32'(k);
      @(posedge clk); #1;
    end
    check("rst_seq_beat", bus_if.icache_rdata, 32'h72);
    bus_if.mem_rdata = 32'h73;
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst_async");
    bus_if.mem_rvalid = 1'b0;
    @(posedge clk); #1;
    check_zero("rst_held");
    rst = 1'b0;
    do_txn(GNT_I, 32'h300, 1'b0, 32'h50, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
